// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with valid/ready flow control.
// Define SHIFTER_ROTATE_EN to build the rotate commands; otherwise they report err_o.
module pipelined_shifter #(
   parameter int unsigned  DATA_W      = 32,
   parameter int unsigned  PIPE_STAGES = 2,
   parameter int unsigned  TAG_W       = 4,
   localparam int unsigned SHAMT_W     = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [2:0]         cmd_i,
   input  logic [TAG_W-1:0]   tag_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [DATA_W-1:0]  data_o,
   output logic [TAG_W-1:0]   tag_o,
   output logic               err_o
);

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } op_e;

   function automatic int unsigned levels_in(input int unsigned s);
      return SHAMT_W / PIPE_STAGES + ((s < SHAMT_W % PIPE_STAGES) ? 1 : 0);
   endfunction

   // Level position p counts from the largest shift: p = 0 shifts by 2^(SHAMT_W-1).
   function automatic int unsigned stage_of(input int unsigned p);
      int unsigned acc;
      int unsigned stg;
      logic        found;
      acc   = 0;
      stg   = PIPE_STAGES - 1;
      found = 1'b0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
         acc = acc + levels_in(s);
         if (!found && p < acc) begin
            stg   = s;
            found = 1'b1;
         end
      end
      return stg;
   endfunction

   function automatic logic [DATA_W-1:0] shift_level(input logic [DATA_W-1:0] x,
                                                     input op_e op,
                                                     input int unsigned amt);
      logic [DATA_W-1:0] r;
      case (op)
         OP_SLL:  r = x << amt;
         OP_SRL:  r = x >> amt;
         OP_SRA:  r = $unsigned($signed(x) >>> amt);
`ifdef SHIFTER_ROTATE_EN
         OP_ROL:  r = (x << amt) | (x >> (DATA_W - amt));
         OP_ROR:  r = (x >> amt) | (x << (DATA_W - amt));
`endif
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] apply_stage(input logic [DATA_W-1:0]  x,
                                                     input op_e                op,
                                                     input logic [SHAMT_W-1:0] shamt,
                                                     input int unsigned        s);
      logic [DATA_W-1:0] r;
      r = x;
      for (int unsigned p = 0; p < SHAMT_W; p++) begin
         if (stage_of(p) == s && shamt[SHAMT_W-1-p])
            r = shift_level(r, op, 1 << (SHAMT_W - 1 - p));
      end
      return r;
   endfunction

   logic [PIPE_STAGES-1:0] valid_q, valid_d, adv;
   logic [PIPE_STAGES-1:0] err_q, err_d;
   logic [DATA_W-1:0]      data_q  [PIPE_STAGES];
   logic [DATA_W-1:0]      data_d  [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];
   op_e                    op_q    [PIPE_STAGES];
   op_e                    op_d    [PIPE_STAGES];
   logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
   logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];

   op_e                in_op;
   logic               in_err;
   logic [SHAMT_W-1:0] in_shamt;
   logic               accept;
   logic               free;

   // Reserved commands pass through untouched by forcing a zero shift.
   always_comb begin
      in_op    = OP_SLL;
      in_err   = 1'b0;
      in_shamt = shamt_i;
      case (cmd_i)
         3'b000: in_op = OP_SLL;
         3'b001: in_op = OP_SRL;
         3'b010: in_op = OP_SRA;
`ifdef SHIFTER_ROTATE_EN
         3'b011: in_op = OP_ROL;
         3'b100: in_op = OP_ROR;
`endif
         default: begin
            in_err   = 1'b1;
            in_shamt = '0;
         end
      endcase
   end

   // Walk from the output back: "free" means the next stage can take a result this edge.
   always_comb begin
      adv  = '0;
      free = ready_i & ~flush_i;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
         adv[PIPE_STAGES-1-i] = valid_q[PIPE_STAGES-1-i] & free;
         free = ~valid_q[PIPE_STAGES-1-i] | adv[PIPE_STAGES-1-i];
      end
      ready_o = ~flush_i & free;
      accept  = valid_i & ready_o;
   end

   always_comb begin
      valid_d[0] = ~flush_i & (accept | (valid_q[0] & ~adv[0]));
      data_d[0]  = data_q[0];
      tag_d[0]   = tag_q[0];
      err_d[0]   = err_q[0];
      op_d[0]    = op_q[0];
      shamt_d[0] = shamt_q[0];
      if (accept) begin
         data_d[0]  = apply_stage(data_i, in_op, in_shamt, 0);
         tag_d[0]   = tag_i;
         err_d[0]   = in_err;
         op_d[0]    = in_op;
         shamt_d[0] = in_shamt;
      end
      for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
         valid_d[k] = ~flush_i & (adv[k-1] | (valid_q[k] & ~adv[k]));
         data_d[k]  = data_q[k];
         tag_d[k]   = tag_q[k];
         err_d[k]   = err_q[k];
         op_d[k]    = op_q[k];
         shamt_d[k] = shamt_q[k];
         if (adv[k-1]) begin
            data_d[k]  = apply_stage(data_q[k-1], op_q[k-1], shamt_q[k-1], k);
            tag_d[k]   = tag_q[k-1];
            err_d[k]   = err_q[k-1];
            op_d[k]    = op_q[k-1];
            shamt_d[k] = shamt_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            data_q[k]  <= '0;
            tag_q[k]   <= '0;
            op_q[k]    <= OP_SLL;
            shamt_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            data_q[k]  <= data_d[k];
            tag_q[k]   <= tag_d[k];
            op_q[k]    <= op_d[k];
            shamt_q[k] <= shamt_d[k];
         end
      end
   end

   assign valid_o = valid_q[PIPE_STAGES-1];
   assign data_o  = data_q[PIPE_STAGES-1];
   assign tag_o   = tag_q[PIPE_STAGES-1];
   assign err_o   = err_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (DATA_W=32, PIPE_STAGES=2); honours SHIFTER_ROTATE_EN.
module tb_pipelined_shifter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic [4:0]  shamt_i;
   logic [2:0]  cmd_i;
   logic [3:0]  tag_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic [3:0]  tag_o;
   logic        err_o;

   always #5 clk = ~clk;

   pipelined_shifter #(.DATA_W(32), .PIPE_STAGES(2), .TAG_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .shamt_i(shamt_i), .cmd_i(cmd_i), .tag_i(tag_i), .valid_o(valid_o),
      .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o), .err_o(err_o)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Bit-by-bit reference: each result bit picks its source bit directly.
   function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] d,
                                  input logic [4:0] sh, input logic [3:0] tag);
      exp_t e;
      int   s;
      s      = int'(sh);
      e.tag  = tag;
      e.err  = 1'b0;
      e.data = d;
      case (cmd)
         3'd0: for (int i = 0; i < 32; i++) e.data[i] = (i >= s) ? d[i-s] : 1'b0;
         3'd1: for (int i = 0; i < 32; i++) e.data[i] = (i + s < 32) ? d[i+s] : 1'b0;
         3'd2: for (int i = 0; i < 32; i++) e.data[i] = (i + s < 32) ? d[i+s] : d[31];
`ifdef SHIFTER_ROTATE_EN
         3'd3: for (int i = 0; i < 32; i++) e.data[i] = d[(i + 32 - s) % 32];
         3'd4: for (int i = 0; i < 32; i++) e.data[i] = d[(i + s) % 32];
`endif
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Scoreboard: push at acceptance, compare head whenever valid_o is up, pop on handshake.
   always @(negedge clk) begin
      if (!reset_n) begin
         sb_q.delete();
      end else begin
         if (valid_o && !flush_i) begin
            compared++;
            if (sb_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_result: data_o=%h tag_o=%h err_o=%b with nothing pending",
                        data_o, tag_o, err_o);
            end else begin
               if ({data_o, tag_o, err_o} !== sb_q[0]) begin
                  mismatched++;
                  $display("FAIL %s: got data=%h tag=%h err=%b, expected data=%h tag=%h err=%b",
                           ready_i ? "result" : "stall_hold", data_o, tag_o, err_o,
                           sb_q[0].data, sb_q[0].tag, sb_q[0].err);
               end
               if (ready_i) void'(sb_q.pop_front());
            end
         end
         if (flush_i) sb_q.delete();
         if (valid_i && ready_o) sb_q.push_back(model(cmd_i, data_i, shamt_i, tag_i));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the end of the run");
      $fatal(1);
   end

   task automatic send(input logic [2:0] cmd, input logic [31:0] d,
                       input logic [4:0] sh, input logic [3:0] tag);
      int n;
      valid_i = 1'b1; cmd_i = cmd; data_i = d; shamt_i = sh; tag_i = tag;
      n = 0;
      @(negedge clk);
      while (!ready_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!ready_o) begin
         compared++; mismatched++;
         $display("FAIL send_accept: ready_o=0, required 1 within 20 cycles");
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!valid_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!valid_o) begin
         compared++; mismatched++;
         $display("FAIL wait_valid: valid_o=0, required 1 within 20 cycles");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (sb_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      data_i = '0; shamt_i = '0; cmd_i = '0; tag_i = '0;
      #1 reset_n = 1'b0;
      #1;
      compared++;
      if ({valid_o, data_o, tag_o, err_o} !== 38'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: valid=%b data=%h tag=%h err=%b, required all 0",
                  valid_o, data_o, tag_o, err_o);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      compared++;
      if (ready_o !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_ready: ready_o=%b, required 1", ready_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      valid_i = 1'b1; cmd_i = 3'd0; data_i = 32'h0000_0001; shamt_i = 5'd31; tag_i = 4'd1;
      @(negedge clk);
      compared++;
      if (ready_o !== 1'b1) begin
         mismatched++;
         $display("FAIL sll_accept: ready_o=%b, required 1", ready_o);
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      compared++;
      if (valid_o !== 1'b0) begin
         mismatched++;
         $display("FAIL sll_latency_early: valid_o=%b one cycle after accept, required 0", valid_o);
      end
      @(negedge clk);
      compared++;
      if (valid_o !== 1'b1 || data_o !== 32'h8000_0000) begin
         mismatched++;
         $display("FAIL sll_latency2: valid_o=%b data_o=%h, required 1 / 80000000", valid_o, data_o);
      end
      @(posedge clk); #1;
      send(3'd1, 32'h8000_0000, 5'd4, 4'd2);
      send(3'd2, 32'h8000_0000, 5'd4, 4'd3);
      wait_valid();
      compared++;
      if (data_o !== 32'h0800_0000) begin
         mismatched++;
         $display("FAIL srl: data_o=%h, required 08000000", data_o);
      end
      @(negedge clk);
      compared++;
      if (valid_o !== 1'b1 || data_o !== 32'hF800_0000) begin
         mismatched++;
         $display("FAIL sra: valid_o=%b data_o=%h, required 1 / F8000000", valid_o, data_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rotate();
      logic [31:0] exp_ror, exp_rol;
      logic        exp_err;
`ifdef SHIFTER_ROTATE_EN
      exp_ror = 32'h1000_000F; exp_rol = 32'h0000_0003; exp_err = 1'b0;
`else
      exp_ror = 32'h0000_00F1; exp_rol = 32'h8000_0001; exp_err = 1'b1;
`endif
      send(3'd4, 32'h0000_00F1, 5'd4, 4'd4);
      wait_valid();
      compared++;
      if (data_o !== exp_ror || err_o !== exp_err) begin
         mismatched++;
         $display("FAIL ror: data_o=%h err_o=%b, required %h / %b", data_o, err_o, exp_ror, exp_err);
      end
      @(posedge clk); #1;
      send(3'd3, 32'h8000_0001, 5'd1, 4'd5);
      wait_valid();
      compared++;
      if (data_o !== exp_rol || err_o !== exp_err) begin
         mismatched++;
         $display("FAIL rol: data_o=%h err_o=%b, required %h / %b", data_o, err_o, exp_rol, exp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_error();
      send(3'd7, 32'hDEAD_BEEF, 5'd5, 4'd6);
      wait_valid();
      compared++;
      if (data_o !== 32'hDEAD_BEEF || err_o !== 1'b1) begin
         mismatched++;
         $display("FAIL reserved_cmd: data_o=%h err_o=%b, required DEADBEEF / 1", data_o, err_o);
      end
      @(posedge clk); #1;
      send(3'd2, 32'h8000_0000, 5'd0, 4'd7);
      wait_valid();
      compared++;
      if (data_o !== 32'h8000_0000 || err_o !== 1'b0) begin
         mismatched++;
         $display("FAIL sra_zero: data_o=%h err_o=%b, required 80000000 / 0", data_o, err_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit saw_block;
      saw_block = 1'b0;
      fork
         begin
            for (int t = 1; t <= 6; t++)
               send(3'(t % 3), $urandom, 5'(t * 3), 4'(t));
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (!ready_o) saw_block = 1'b1;
            end
            @(posedge clk);
            #1 ready_i = 1'b1;
         end
      join
      compared++;
      if (!saw_block) begin
         mismatched++;
         $display("FAIL stall_backpressure: ready_o stayed 1 during stall, required 0 once full");
      end
      drain();
   endtask

   task automatic test_flush();
      send(3'd0, 32'h0000_00A5, 5'd1, 4'd8);
      send(3'd1, 32'h0000_5A00, 5'd2, 4'd9);
      flush_i = 1'b1;
      valid_i = 1'b1; cmd_i = 3'd0; data_i = 32'h1111_1111; shamt_i = 5'd3; tag_i = 4'd10;
      @(negedge clk);
      compared++;
      if (ready_o !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_ready: ready_o=%b during flush, required 0", ready_o);
      end
      @(posedge clk); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         compared++;
         if (valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_discard: valid_o=%b after flush, required 0", valid_o);
         end
      end
      @(posedge clk); #1;
      valid_i = 1'b1; cmd_i = 3'd0; data_i = 32'h0000_0003; shamt_i = 5'd8; tag_i = 4'd11;
      @(negedge clk);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      compared++;
      if (valid_o !== 1'b0) begin
         mismatched++;
         $display("FAIL post_flush_early: valid_o=%b, required 0", valid_o);
      end
      @(negedge clk);
      compared++;
      if (valid_o !== 1'b1 || data_o !== 32'h0000_0300 || tag_o !== 4'd11) begin
         mismatched++;
         $display("FAIL post_flush_latency2: valid_o=%b data_o=%h tag_o=%h, required 1 / 00000300 / b",
                  valid_o, data_o, tag_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      send(3'd0, 32'h0000_0F0F, 5'd4, 4'd12);
      send(3'd1, 32'hF0F0_0000, 5'd4, 4'd13);
      #1 reset_n = 1'b0;
      #1;
      compared++;
      if ({valid_o, data_o, tag_o, err_o} !== 38'd0) begin
         mismatched++;
         $display("FAIL reset_async: valid=%b data=%h tag=%h err=%b, required all 0",
                  valid_o, data_o, tag_o, err_o);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         compared++;
         if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_stale: valid_o=%b ready_o=%b after release, required 0 / 1",
                     valid_o, ready_o);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rotate();
      test_error();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; power of two, 8..64.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, register stages; 1..log2(DATA_W).
REQ-003 SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-004 SHALL derive SHAMT_W = log2(DATA_W) internally; not overridable.
REQ-005 SHALL have ports in this order, with clock and reset as decided:
  clk        in   1        single clock, rising edge
  reset_n    in   1        asynchronous, active-low reset
  flush_i    in   1        discard all in-flight operations
  valid_i    in   1        input operation valid
  ready_o    out  1        block can accept input
  data_i     in   DATA_W   operand
  shamt_i    in   SHAMT_W  shift amount
  cmd_i      in   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; others reserved
  tag_i      in   TAG_W    sideband tag, passed through unchanged
  valid_o    out  1        result valid
  ready_i    in   1        consumer accepts result
  data_o     out  DATA_W   result
  tag_o      out  TAG_W    tag of result
  err_o      out  1        reserved or disabled command; qualified by valid_o

Function
REQ-006 SHALL accept an operation on a rising edge where valid_i & ready_o are high.
REQ-007 SHALL present an operation's result on valid_o exactly PIPE_STAGES cycles after acceptance when ready_i stays high.
REQ-008 SHALL sustain one accepted operation per cycle when ready_i is constantly high.
REQ-009 SHALL advance stage k only when stage k+1 is empty or is advancing in the same cycle; the output stage advances on valid_o & ready_i.
REQ-010 SHALL drive ready_o = ~flush_i & (stage 0 empty | stage 0 advancing).
REQ-011 SHALL hold data_o, tag_o and err_o stable while valid_o & ~ready_i.
REQ-012 SHALL deliver results in acceptance order, with no loss or duplication under any ready_i pattern.
REQ-013 SHALL implement SHAMT_W binary levels (shift by 2^(SHAMT_W-1) down to 1); levels are distributed across stages largest-first, with earlier stages taking any extra level.
REQ-014 SHALL compute SLL/SRL with zero fill, SRA with data_i[DATA_W-1] fill, and ROL/ROR with bits re-entering at the opposite end.
REQ-015 SHALL, for shamt_i = 0, return data_i unchanged for every legal command.
REQ-016 SHALL, for a reserved cmd_i, return data_i unchanged with err_o = 1; otherwise err_o = 0.
REQ-017 SHALL, on a cycle with flush_i high, clear every stage valid bit at that edge, accept no input and complete no handshake on the output side.
REQ-018 SHALL make the result independent of PIPE_STAGES; only latency changes.

Reset
REQ-019 SHALL, while reset_n is low, asynchronously force all stage valid bits, valid_o, data_o, tag_o and err_o to 0.
REQ-020 SHALL drive ready_o = 1 in the first cycle after reset_n deasserts, provided flush_i is low.
REQ-021 SHALL discard in-flight operations when reset is asserted mid-operation; none emerge after release.

Configuration
REQ-022 SHALL, with SHIFTER_ROTATE_EN defined, implement ROL/ROR per REQ-014.
REQ-023 SHALL, without SHIFTER_ROTATE_EN, treat 011 and 100 as reserved per REQ-016 and synthesise no rotate wrap-around logic.

Verification (DATA_W=32, PIPE_STAGES=2)
REQ-024 SHALL test: SLL 0x00000001 by 31 -> data_o 0x80000000, valid_o 2 cycles after accept; SRL 0x80000000 by 4 -> 0x08000000; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-025 SHALL test: ROR 0x000000F1 by 4 -> 0x1000000F and ROL 0x80000001 by 1 -> 0x00000003 with macro; without macro -> data_o 0x000000F1 / 0x80000001, err_o=1.
REQ-026 SHALL test: tags 1..6 issued back-to-back, ready_i low for 3 cycles mid-stream -> ready_o drops once pipeline full, results emerge in order with matching tags, data_o held while stalled.
REQ-027 SHALL test: cmd 111 with 0xDEADBEEF -> data_o 0xDEADBEEF, err_o=1; shamt 0 SRA 0x80000000 -> 0x80000000, err_o=0.
REQ-028 SHALL test: flush_i pulsed with two ops in flight -> neither emerges, ready_o=0 that cycle, next op has latency 2.
REQ-029 SHALL test: reset_n low mid-stream -> valid_o, data_o 0 immediately (asynchronously); no stale result after release.
